// File: rtl/counters_pkg.sv
// Shared types and helpers for the counters board user-input path.
`default_nettype none

package counters_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } entry_state_t;

  // New value of one digit after a single up/down step; no carry out.
  function automatic logic [3:0] digit_step(
    input logic [3:0] d,
    input logic       up,
    input logic       dec
  );
    logic [3:0] r;
    if (dec) begin
      if (up) r = (d >= 4'd9) ? 4'd0 : d + 4'd1;
      else    r = ((d == 4'd0) || (d > 4'd9)) ? 4'd9 : d - 4'd1;
    end else begin
      r = up ? d + 4'd1 : d - 4'd1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, millisecond-based debounce and rising-edge pulse
// for one push-button.
`default_nettype none

module btn_debounce #(
  parameter int DEBOUNCE_MS = 20
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ce1ms_i,
  input  logic btn_i,
  output logic pressed_o,
  output logic rise_o
);

  localparam logic [8:0] C_DEB_LIMIT = 9'(DEBOUNCE_MS);

  logic [1:0] sync_q;
  logic [7:0] cnt_q, cnt_d;
  logic       pressed_q, pressed_d;
  logic       rise_q;
  logic       s;

  assign s = sync_q[1];

  always_comb begin
    cnt_d     = cnt_q;
    pressed_d = pressed_q;
    if (s == pressed_q) begin
      cnt_d = '0;
    end else if (ce1ms_i) begin
      if (({1'b0, cnt_q} + 9'd1) == C_DEB_LIMIT) begin
        pressed_d = s;
        cnt_d     = '0;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      pressed_q <= 1'b0;
      rise_q    <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], btn_i};
      cnt_q     <= cnt_d;
      pressed_q <= pressed_d;
      // Aligned with the first cycle pressed_q reads 1.
      rise_q    <= pressed_d & ~pressed_q;
    end
  end

  assign pressed_o = pressed_q;
  assign rise_o    = rise_q;

endmodule

`default_nettype wire

// File: rtl/digit_entry.sv
// Push-button digit editor: steps the nibble of dat selected by ptr_i once
// per press and then at an auto-repeat rate while the button is held.
`default_nettype none

module digit_entry
  import counters_pkg::*;
#(
  parameter int          DEBOUNCE_MS = 20,
  parameter int          HOLD_MS     = 500,
  parameter int          REPEAT_MS   = 100,
  parameter logic [15:0] INIT        = 16'h0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ce1ms_i,
  input  logic        btn_i,
  input  logic [1:0]  ptr_i,
  input  logic        up_i,
  input  logic        dec_i,
  output logic [15:0] dat_o,
  output logic        stb_o,
  output logic        pressed_o
);

  localparam logic [10:0] C_HOLD_LIMIT   = 11'(HOLD_MS);
  localparam logic [10:0] C_REPEAT_LIMIT = 11'(REPEAT_MS);

  entry_state_t state_q, state_d;
  logic [9:0]   timer_q, timer_d;
  logic [15:0]  dat_q, dat_d;
  logic         stb_q;
  logic         step;
  logic         pressed, rise;
  logic [10:0]  limit;

  btn_debounce #(
    .DEBOUNCE_MS (DEBOUNCE_MS)
  ) u_debounce (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .ce1ms_i   (ce1ms_i),
    .btn_i     (btn_i),
    .pressed_o (pressed),
    .rise_o    (rise)
  );

  assign limit = (state_q == HOLD) ? C_HOLD_LIMIT : C_REPEAT_LIMIT;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    step    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          step    = 1'b1;
          timer_d = '0;
          state_d = HOLD;
        end
      end
      HOLD, REPEAT: begin
        // Release wins over a timer expiry in the same cycle.
        if (!pressed) begin
          timer_d = '0;
          state_d = IDLE;
        end else if (ce1ms_i) begin
          if (({1'b0, timer_q} + 11'd1) == limit) begin
            step    = 1'b1;
            timer_d = '0;
            state_d = REPEAT;
          end else begin
            timer_d = timer_q + 10'd1;
          end
        end
      end
      default: begin
        timer_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    dat_d = dat_q;
    if (step) begin
      dat_d[{ptr_i, 2'b00} +: 4] = digit_step(dat_q[{ptr_i, 2'b00} +: 4], up_i, dec_i);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      timer_q <= '0;
      dat_q   <= INIT;
      stb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      dat_q   <= dat_d;
      stb_q   <= step;
    end
  end

  assign dat_o     = dat_q;
  assign stb_o     = stb_q;
  assign pressed_o = pressed;

endmodule

`default_nettype wire

// File: tb/tb_digit_entry.sv
// Scoreboard bench for digit_entry: press schedules in whole milliseconds,
// expected dat values queued per step and matched against every stb.
`default_nettype none

module tb_digit_entry;

  localparam int DEB  = 4;
  localparam int HOLD = 10;
  localparam int REP  = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce1ms = 1'b0;
  logic        btn = 1'b0;
  logic [1:0]  ptr = 2'd0;
  logic        up = 1'b1;
  logic        dec = 1'b0;
  logic [15:0] dat;
  logic        stb;
  logic        pressed;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [15:0] model_dat = 16'h0000;
  logic [15:0] exp_q[$];
  logic        prev_stb = 1'b0;

  digit_entry #(
    .DEBOUNCE_MS (DEB),
    .HOLD_MS     (HOLD),
    .REPEAT_MS   (REP),
    .INIT        (16'h0000)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .ce1ms_i   (ce1ms),
    .btn_i     (btn),
    .ptr_i     (ptr),
    .up_i      (up),
    .dec_i     (dec),
    .dat_o     (dat),
    .stb_o     (stb),
    .pressed_o (pressed)
  );

  always #5 clk = ~clk;

  // One-clock enable every 8 clocks stands in for the 1 ms tick.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      ce1ms = (cyc % 8 == 0);
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Digit arithmetic taken straight from the decimal/hex rules.
  function automatic logic [15:0] apply_step(input logic [15:0] v, input int p,
                                             input bit u, input bit bcd);
    int d;
    int n;
    logic [15:0] r;
    d = (v >> (4 * p)) % 16;
    if (!bcd)     n = u ? (d + 1) % 16 : (d + 15) % 16;
    else if (u)   n = (d >= 9) ? 0 : d + 1;
    else          n = (d == 0 || d > 9) ? 9 : d - 1;
    r = v;
    r[4 * p +: 4] = 4'(n);
    return r;
  endfunction

  // Steps produced by h consecutive ms of clean press.
  function automatic int n_steps(input int h);
    if (h < DEB)  return 0;
    if (h < HOLD) return 1;
    return 2 + (h - HOLD) / REP;
  endfunction

  task automatic expect_steps(input int h);
    for (int k = 0; k < n_steps(h); k++) begin
      model_dat = apply_step(model_dat, int'(ptr), up, dec);
      exp_q.push_back(model_dat);
    end
  endtask

  // Returns on the falling edge just after the n-th tick edge.
  task automatic ms(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clk); while (!ce1ms);
    end
    @(negedge clk);
  endtask

  task automatic drain(input string nm);
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    check(nm, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic release_wait();
    btn = 1'b0;
    ms(DEB + 2);
    drain("steps_delivered");
    check("released", {31'd0, pressed}, 32'd0);
  endtask

  task automatic press(input int h);
    expect_steps(h);
    btn = 1'b1;
    ms(h);
    release_wait();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_dat = 16'h0000;
    exp_q.delete();
    ms(1);
  endtask

  initial begin
    @(negedge clk);
    forever begin
      @(negedge clk);
      if (stb) begin
        n_tests++;
        if (prev_stb) begin
          n_fail++;
          $display("FAIL stb_back_to_back actual=1 required=0");
        end else if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_stb actual=%h required=no_step", dat);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          if (dat !== e) begin
            n_fail++;
            $display("FAIL stb_dat actual=%h required=%h", dat, e);
          end
        end
      end
      prev_stb = stb;
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout actual=running required=finished");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    #2;
    check("reset_dat", {16'd0, dat}, 32'h0);
    check("reset_stb", {31'd0, stb}, 32'd0);
    check("reset_pressed", {31'd0, pressed}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    ms(1);

    // Clean single press, no repeat.
    ptr = 2'd0; up = 1'b1; dec = 1'b0;
    press(6);
    check("clean_dat", {16'd0, dat}, 32'h0001);

    // Bouncy press settling high.
    do_reset();
    btn = 1'b1; ms(1);
    btn = 1'b0; ms(1);
    expect_steps(8);
    btn = 1'b1; ms(8);
    release_wait();
    check("bounce_dat", {16'd0, dat}, 32'h0001);

    // Long hold: initial step plus four repeats.
    do_reset();
    ptr = 2'd1;
    press(20);
    check("hold_dat", {16'd0, dat}, 32'h0050);

    // BCD wrap on the top digit.
    do_reset();
    ptr = 2'd3; up = 1'b1; dec = 1'b1;
    repeat (9) press(6);
    check("bcd_preset9", {28'd0, dat[15:12]}, 32'd9);
    press(6);
    check("bcd_up_wrap", {28'd0, dat[15:12]}, 32'd0);
    up = 1'b0;
    press(6);
    check("bcd_down_wrap", {28'd0, dat[15:12]}, 32'd9);
    up = 1'b1; dec = 1'b0;
    press(6);
    check("hex_to_A", {28'd0, dat[15:12]}, 32'hA);
    up = 1'b0; dec = 1'b1;
    press(6);
    check("bcd_A_down", {28'd0, dat[15:12]}, 32'd9);

    // Hex wrap without carry or borrow.
    do_reset();
    ptr = 2'd1; up = 1'b1; dec = 1'b0;
    repeat (15) press(5);
    check("hex_preset", {16'd0, dat}, 32'h00F0);
    press(5);
    check("hex_up_nocarry", {16'd0, dat}, 32'h0000);
    ptr = 2'd2; up = 1'b0;
    press(5);
    check("hex_down_noborrow", {16'd0, dat}, 32'h0F00);

    // Reset while repeating with the button still held.
    do_reset();
    ptr = 2'd0; up = 1'b1; dec = 1'b0;
    btn = 1'b1;
    ms(DEB);
    expect_steps(14);
    ms(14);
    check("pre_reset_pending", 32'(exp_q.size()), 32'd0);
    check("pre_reset_pressed", {31'd0, pressed}, 32'd1);
    check("pre_reset_dat", {16'd0, dat}, 32'h0003);
    #2 rst = 1'b1;
    #1;
    check("midrst_dat", {16'd0, dat}, 32'h0);
    check("midrst_stb", {31'd0, stb}, 32'd0);
    check("midrst_pressed", {31'd0, pressed}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_dat = 16'h0000;
    exp_q.delete();
    expect_steps(14);
    ms(14);
    release_wait();
    check("post_reset_dat", {16'd0, dat}, 32'h0003);

    // Randomised presses, some with a leading bounce.
    for (int it = 0; it < 30; it++) begin
      int h;
      ptr = 2'($urandom_range(0, 3));
      up  = 1'($urandom_range(0, 1));
      dec = 1'($urandom_range(0, 1));
      h   = int'($urandom_range(1, 24));
      if ($urandom_range(0, 3) == 0) begin
        btn = 1'b1; ms(int'($urandom_range(1, DEB - 1)));
        btn = 1'b0; ms(1);
      end
      press(h);
      check("random_dat", {16'd0, dat}, {16'd0, model_dat});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/digit_entry.md
Name: digit_entry

Overview:
- User-input front end for the counters board: the writer side of the 16-bit `dat` word that the seven-segment display reads.
- Synchronises and debounces the raw push-button, then steps the hex/BCD digit selected by `ptr` up or down.
- Supports single press plus auto-repeat on hold.
- Outputs the edited 16-bit value and a one-cycle strobe, suitable for feeding the `di`/`l` load path of a loadable counter or for driving the display directly.
- Timing is derived from the shared 1 ms clock-enable, not from `clk` counts.

Parameters:
- DEBOUNCE_MS, 20, consecutive ce1ms ticks the synchronised button must be stable before the clean level changes (1..255)
- HOLD_MS, 500, ce1ms ticks of continuous clean press before auto-repeat starts (1..1023)
- REPEAT_MS, 100, ce1ms ticks between auto-repeat steps (1..1023)
- INIT, 16'h0000, value of dat after reset

Ports:
- clk  input  1  system clock
- rst  input  1  reset; one clock; reset is asynchronous and active-high
- ce1ms  input  1  one-clk-wide enable, once per millisecond
- btn  input  1  raw button level, asynchronous to clk, 1 = pressed
- ptr  input  2  selected digit: 0 = dat[3:0] ... 3 = dat[15:12]
- up  input  1  1 = increment, 0 = decrement
- dec  input  1  1 = BCD digit range 0..9, 0 = hex range 0..F
- dat  output  16  edited value
- stb  output  1  one-clk pulse, high in the cycle dat takes a new value
- pressed  output  1  debounced button level

Behaviour:
- Reset (async, rst=1):
  - sync flops = 0, pressed = 0, debounce count = 0, FSM = IDLE, timer = 0, dat = INIT, stb = 0.
  - Deassertion is used as-is; no internal reset synchroniser.
- Synchroniser: 2-flop chain on btn; `s` is the second flop. Latency is 2 clk.
- Debounce:
  - If s == pressed, the count clears to 0.
  - Otherwise the count increments on each ce1ms. On the ce1ms where the count reaches DEBOUNCE_MS, pressed <= s and the count clears.
  - Any bounce, i.e. s returning to pressed before terminal count, clears the count.
  - The count holds between ce1ms ticks.
- Step FSM (states IDLE, HOLD, REPEAT), evaluated every clk:
  - IDLE: on rising edge of pressed -> emit step, timer = 0, go HOLD.
  - HOLD: on ce1ms, timer++. When timer reaches HOLD_MS -> emit step, timer = 0, go REPEAT.
  - REPEAT: on ce1ms, timer++. When timer reaches REPEAT_MS -> emit step, timer = 0, stay in REPEAT.
  - HOLD or REPEAT with pressed = 0 -> IDLE, timer = 0, no step. Release has priority over a same-cycle timer expiry.
- Step application (registered):
  - In the cycle after the step is emitted, the nibble d = dat[4*ptr +: 4] is replaced and stb = 1.
  - Other nibbles are unchanged; there is no carry or borrow between digits.
  - Hex mode: up gives d+1 mod 16; down gives d-1 mod 16.
  - BCD mode, up: d == 9 or d > 9 -> 0, else d+1.
  - BCD mode, down: d == 0 -> 9; d > 9 -> 9; else d-1.
  - ptr, up and dec are sampled in the cycle the step is applied. Changing ptr mid-hold retargets later repeats; no step is lost or duplicated.
- End-to-end latency, from btn stable to dat/stb: 2 clk + DEBOUNCE_MS ticks + 2 clk (pressed register, then step register).
- stb is never high for two consecutive clk.
- Reset mid-hold aborts the operation immediately. A button still held after reset release needs a full debounce, then produces a single initial step.

Decomposition:
- Package `counters_pkg`:
  - typedef enum logic [1:0] {IDLE, HOLD, REPEAT} entry_state_t
  - function `digit_step(d, up, dec)` returning the new nibble, reused by the bench model
- Sub-module `btn_debounce` (clk, rst, ce1ms, btn -> pressed, rise): contains the synchroniser, debounce counter and edge detect. Reusable for btn1 elsewhere on the board.
- `digit_entry` contains the FSM, the timer and the nibble update.

Test Plan:
All scenarios use DEBOUNCE_MS=4, HOLD_MS=10, REPEAT_MS=3, INIT=16'h0000, and ce1ms every 8 clk.
- Clean press, hex mode, up=1, ptr=0, held for 6 ms then released -> exactly one stb; dat = 16'h0001; no repeat.
- Bouncy press: btn toggles every 1 ms for 3 ms, then stable high -> no stb during the bounce; one stb about 4 ms after btn settles; dat = 16'h0001.
- Hold: ptr=1, up=1, dec=0, held for 20 ms after pressed rises -> steps at t = 0, 10, 13, 16, 19 ms; dat = 16'h0050; stb count = 5.
- BCD wrap:
  - dec=1, ptr=3, nibble preset to 9 via presses, then one up press -> dat[15:12] = 0.
  - up=0 from 0 -> 9.
  - Hex nibble A with dec=1, down -> 9.
- Hex wrap with no carry: dat = 16'h00F0, ptr=1, up -> 16'h0000; ptr=2, down -> 16'h0F00.
- Reset mid-REPEAT: pulse rst while btn is still held -> dat = 0, stb = 0, pressed = 0 immediately. After reset release, one step after the 4 ms debounce, then the repeat schedule restarts from HOLD.
